// File: rtl/ibex_pmp_csr.sv
// PMP CSR storage: pmpcfg0-3 / pmpaddr0-15 with WARL and lock rules, feeding
// the PMP checker with per-region cfg and 34-bit addresses.
// Optional: define IBEX_PMP_CSR_SHADOW_EN for inverted shadow copies and a
// sticky mismatch alarm; otherwise alarm_o is tied 0.

package ibex_pkg;
    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;
endpackage

// One PMP entry: cfg byte and raw pmpaddr storage with WARL/lock filtering.
module ibex_pmp_csr_entry
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_we_i,
    input  logic [7:0]  cfg_wdata_i,
    input  logic        addr_we_i,
    input  logic [31:0] addr_wdata_i,
    input  logic        addr_lock_i,
    output pmp_cfg_t    cfg_o,
    output logic [31:0] addr_o
`ifdef IBEX_PMP_CSR_SHADOW_EN
    ,
    output logic        mismatch_o
`endif
);
    pmp_cfg_t    cfg_q, cfg_d;
    logic [31:0] addr_q, addr_d;

    // Next-state: a locked entry ignores writes; R=0,W=1 and (G>=1) NA4 are fixed up.
    always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        if (cfg_we_i && !cfg_q.lock) begin
            cfg_d.lock  = cfg_wdata_i[7];
            cfg_d.mode  = pmp_cfg_mode_e'(cfg_wdata_i[4:3]);
            if (PMPGranularity >= 1 && cfg_wdata_i[4:3] == 2'b10) begin
                cfg_d.mode = cfg_q.mode;
            end
            cfg_d.exec  = cfg_wdata_i[2];
            cfg_d.write = cfg_wdata_i[1] & cfg_wdata_i[0];
            cfg_d.read  = cfg_wdata_i[0];
        end
        if (addr_we_i && !cfg_q.lock && !addr_lock_i) begin
            addr_d = addr_wdata_i;
        end
    end

    // Primary storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q  <= '0;
            addr_q <= '0;
        end else begin
            cfg_q  <= cfg_d;
            addr_q <= addr_d;
        end
    end

    assign cfg_o  = cfg_q;
    assign addr_o = addr_q;

`ifdef IBEX_PMP_CSR_SHADOW_EN
    logic [5:0]  cfg_sh_q;
    logic [31:0] addr_sh_q;

    // Inverted shadow copies, written alongside the primary registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_sh_q  <= '1;
            addr_sh_q <= '1;
        end else begin
            cfg_sh_q  <= ~cfg_d;
            addr_sh_q <= ~addr_d;
        end
    end

    assign mismatch_o = (cfg_q != ~cfg_sh_q) || (addr_q != ~addr_sh_q);
`endif
endmodule

module ibex_pmp_csr
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csr_req_i,
    output logic        csr_gnt_o,
    input  logic [11:0] csr_addr_i,
    input  logic [1:0]  csr_op_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_rvalid_o,
    output logic [31:0] csr_rdata_o,
    output logic        csr_err_o,
    output pmp_cfg_t    csr_pmp_cfg_o  [PMPNumRegions],
    output logic [33:0] csr_pmp_addr_o [PMPNumRegions],
    output logic        alarm_o
);
    localparam int G = int'(PMPGranularity);

    // Readback view of pmpaddr: granule bits forced according to mode.
    function automatic logic [31:0] mask_addr(logic [31:0] a, pmp_cfg_mode_e m);
        logic [31:0] r;
        r = a;
        for (int b = 0; b < 32; b++) begin
            if (G >= 1 && b < G && !m[1]) r[b] = 1'b0;
            if (G >= 2 && b < G - 1 && m == PMP_MODE_NAPOT) r[b] = 1'b1;
        end
        return r;
    endfunction

    pmp_cfg_t    cfg_all  [16];
    logic [31:0] addr_raw [16];
    logic [31:0] addr_rd  [16];
    logic [7:0]  cfg_byte [16];
    logic [15:0] addr_lock;

    logic        is_cfg, is_addr, legal, we;
    logic [31:0] old_val, new_val;

    logic        rvalid_q, err_q;
    logic [31:0] rdata_q;

    assign is_cfg  = (csr_addr_i[11:2] == 10'h0E8);
    assign is_addr = (csr_addr_i[11:4] == 8'h3B);
    assign legal   = is_cfg | is_addr;
    assign we      = csr_req_i && !rst_i && legal &&
                     (csr_op_i == 2'd1 || (csr_op_i[1] && csr_wdata_i != 32'h0));
    assign csr_gnt_o = ~rst_i;

    // Old value of the addressed register (this is also the RMW base).
    always_comb begin
        old_val = 32'h0;
        if (is_cfg) begin
            for (int j = 0; j < 4; j++) begin
                old_val[8*j +: 8] = cfg_byte[{csr_addr_i[1:0], 2'(j)}];
            end
        end else if (is_addr) begin
            old_val = addr_rd[csr_addr_i[3:0]];
        end
    end

    // Read-modify-write operand.
    always_comb begin
        new_val = csr_wdata_i;
        case (csr_op_i)
            2'd2:    new_val = old_val | csr_wdata_i;
            2'd3:    new_val = old_val & ~csr_wdata_i;
            default: new_val = csr_wdata_i;
        endcase
    end

`ifdef IBEX_PMP_CSR_SHADOW_EN
    logic [15:0] mismatch;
`endif

    for (genvar i = 0; i < 16; i++) begin : g_ent
        if (i < PMPNumRegions) begin : g_impl
            ibex_pmp_csr_entry #(.PMPGranularity(PMPGranularity)) u_ent (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .cfg_we_i     (we && is_cfg && csr_addr_i[1:0] == 2'(i / 4)),
                .cfg_wdata_i  (new_val[8*(i%4) +: 8]),
                .addr_we_i    (we && is_addr && csr_addr_i[3:0] == 4'(i)),
                .addr_wdata_i (new_val),
                .addr_lock_i  (addr_lock[i]),
                .cfg_o        (cfg_all[i]),
                .addr_o       (addr_raw[i])
`ifdef IBEX_PMP_CSR_SHADOW_EN
                ,
                .mismatch_o   (mismatch[i])
`endif
            );
        end else begin : g_none
            assign cfg_all[i]  = '0;
            assign addr_raw[i] = '0;
`ifdef IBEX_PMP_CSR_SHADOW_EN
            assign mismatch[i] = 1'b0;
`endif
        end

        // A TOR region above locks this entry's address as its lower bound.
        if (i < 15) begin : g_lk
            assign addr_lock[i] = cfg_all[i+1].lock && cfg_all[i+1].mode == PMP_MODE_TOR;
        end else begin : g_lk_top
            assign addr_lock[i] = 1'b0;
        end

        assign cfg_byte[i] = {cfg_all[i].lock, 2'b00, cfg_all[i].mode,
                              cfg_all[i].exec, cfg_all[i].write, cfg_all[i].read};
        assign addr_rd[i]  = mask_addr(addr_raw[i], cfg_all[i].mode);
    end

    for (genvar i = 0; i < PMPNumRegions; i++) begin : g_out
        assign csr_pmp_cfg_o[i]  = cfg_all[i];
        assign csr_pmp_addr_o[i] = {addr_rd[i], 2'b00};
    end

    // Single-cycle response: old value, or 0 with err for unknown CSRs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= csr_req_i;
            rdata_q  <= (csr_req_i && legal) ? old_val : 32'h0;
            err_q    <= csr_req_i && !legal;
        end
    end

    assign csr_rvalid_o = rvalid_q;
    assign csr_rdata_o  = rdata_q;
    assign csr_err_o    = err_q;

`ifdef IBEX_PMP_CSR_SHADOW_EN
    logic alarm_q;

    // Sticky alarm: any primary/shadow disagreement holds until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) alarm_q <= 1'b0;
        else       alarm_q <= alarm_q | (|mismatch);
    end

    assign alarm_o = alarm_q;
`else
    assign alarm_o = 1'b0;
`endif
endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Bench for ibex_pmp_csr: a G=0 and a G=2 instance, responses checked
// against a queue of expected (cycle, rdata, err) entries.
module tb_ibex_pmp_csr;
    import ibex_pkg::*;

    localparam logic [1:0] RD = 2'd0, WR = 2'd1, ST = 2'd2, CL = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [11:0] addr = '0;
    logic [1:0]  op = '0;
    logic [31:0] wdata = '0;

    logic        gnt0, rv0, err0, alarm0;
    logic [31:0] rd0;
    pmp_cfg_t    cfg0 [4];
    logic [33:0] pa0  [4];
    logic        gnt1, rv1, err1, alarm1;
    logic [31:0] rd1;
    pmp_cfg_t    cfg1 [4];
    logic [33:0] pa1  [4];

    int unsigned cyc = 0;
    int          n_chk = 0, n_pass = 0;

    typedef struct {
        bit          d2;
        logic [31:0] rdata;
        bit          err;
        int unsigned cyc;
    } sb_t;
    sb_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ibex_pmp_csr #(.PMPGranularity(0), .PMPNumRegions(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .csr_req_i(req0), .csr_gnt_o(gnt0),
        .csr_addr_i(addr), .csr_op_i(op), .csr_wdata_i(wdata),
        .csr_rvalid_o(rv0), .csr_rdata_o(rd0), .csr_err_o(err0),
        .csr_pmp_cfg_o(cfg0), .csr_pmp_addr_o(pa0), .alarm_o(alarm0));

    ibex_pmp_csr #(.PMPGranularity(2), .PMPNumRegions(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .csr_req_i(req1), .csr_gnt_o(gnt1),
        .csr_addr_i(addr), .csr_op_i(op), .csr_wdata_i(wdata),
        .csr_rvalid_o(rv1), .csr_rdata_o(rd1), .csr_err_o(err1),
        .csr_pmp_cfg_o(cfg1), .csr_pmp_addr_o(pa1), .alarm_o(alarm1));

    // Drive one request this cycle (called at posedge+1) and record its expected response.
    task automatic issue(bit d2, logic [1:0] o, logic [11:0] a, logic [31:0] wd,
                         logic [31:0] er, bit ee);
        sb_t e;
        req0 = !d2; req1 = d2; op = o; addr = a; wdata = wd;
        e.d2 = d2; e.rdata = er; e.err = ee; e.cyc = cyc + 1;
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0; op = RD; addr = '0; wdata = '0;
        @(posedge clk); #1;
    endtask

    // Pops the scoreboard whenever either DUT returns a response.
    task automatic monitor();
        sb_t         e;
        logic [31:0] ard;
        logic        aerr;
        forever begin
            @(negedge clk);
            while (sbq.size() != 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                n_chk++;
                $display("FAIL missing_rvalid: got none want response due at cycle %0d", e.cyc);
            end
            if (rv0 || rv1) begin
                n_chk++;
                if (sbq.size() == 0) begin
                    $display("FAIL unexpected_rvalid: got rv0=%b rv1=%b want none at cycle %0d", rv0, rv1, cyc);
                end else begin
                    e = sbq.pop_front();
                    ard  = e.d2 ? rd1 : rd0;
                    aerr = e.d2 ? err1 : err0;
                    if ((e.d2 ? rv1 : rv0) !== 1'b1 || e.cyc != cyc)
                        $display("FAIL rvalid_timing: got cycle %0d want %0d", cyc, e.cyc);
                    else n_pass++;
                    n_chk++;
                    if (ard !== e.rdata)
                        $display("FAIL rdata: got %h want %h (cycle %0d)", ard, e.rdata, cyc);
                    else n_pass++;
                    n_chk++;
                    if (aerr !== e.err)
                        $display("FAIL err: got %b want %b (cycle %0d)", aerr, e.err, cyc);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset();
        n_chk++; if (gnt0 !== 1'b0) $display("FAIL gnt_in_reset: got %b want 0", gnt0); else n_pass++;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_chk++; if ({rv0, err0, rd0} !== 34'h0) $display("FAIL reset_resp: got rv=%b err=%b rd=%h want 0", rv0, err0, rd0); else n_pass++;
        n_chk++; if (alarm0 !== 1'b0 || alarm1 !== 1'b0) $display("FAIL reset_alarm: got %b/%b want 0", alarm0, alarm1); else n_pass++;
        n_chk++; if (cfg0[0] !== '0 || cfg0[3] !== '0 || pa0[0] !== '0 || pa0[3] !== '0)
            $display("FAIL reset_state: got cfg0=%h addr0=%h want 0", cfg0[0], pa0[0]); else n_pass++;
        n_chk++; if (gnt0 !== 1'b1) $display("FAIL gnt_after_reset: got %b want 1", gnt0); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_addr();
        issue(0, WR, 12'h3B0, 32'h0000_1000, 32'h0, 0);
        n_chk++; if (pa0[0] !== 34'h0_0000_4000) $display("FAIL addr0_out: got %h want %h", pa0[0], 34'h0_0000_4000); else n_pass++;
        issue(0, RD, 12'h3B0, 32'h0,         32'h0000_1000, 0);
        issue(0, WR, 12'h3B3, 32'hDEAD_BEEF, 32'h0,         0);
        issue(0, ST, 12'h3B3, 32'h0,         32'hDEAD_BEEF, 0);
        issue(0, CL, 12'h3B3, 32'h0,         32'hDEAD_BEEF, 0);
        issue(0, CL, 12'h3B3, 32'hFFFF_0000, 32'hDEAD_BEEF, 0);
        issue(0, RD, 12'h3B3, 32'h0,         32'h0000_BEEF, 0);
        issue(0, WR, 12'h3B5, 32'h0000_ABCD, 32'h0,         0);
        issue(0, RD, 12'h3B5, 32'h0,         32'h0,         0);
        issue(0, WR, 12'h3A1, 32'hFFFF_FFFF, 32'h0,         0);
        issue(0, RD, 12'h3A1, 32'h0,         32'h0,         0);
        idle();
    endtask

    task automatic test_warl();
        issue(0, WR, 12'h3A0, 32'h0000_0802, 32'h0, 0);
        n_chk++; if (cfg0[0].write !== 1'b0 || cfg0[0].read !== 1'b0)
            $display("FAIL warl_rw: got W=%b R=%b want 0 0", cfg0[0].write, cfg0[0].read); else n_pass++;
        n_chk++; if (cfg0[1].mode !== PMP_MODE_TOR) $display("FAIL cfg1_mode: got %b want 01", cfg0[1].mode); else n_pass++;
        issue(0, RD, 12'h3A0, 32'h0,         32'h0000_0800, 0);
        issue(0, WR, 12'h3A0, 32'h0010_0800, 32'h0000_0800, 0);
        issue(0, RD, 12'h3A0, 32'h0,         32'h0010_0800, 0);
        idle();
    endtask

    task automatic test_lock();
        issue(0, WR, 12'h3A0, 32'h0000_8900, 32'h0010_0800, 0);
        issue(0, WR, 12'h3B0, 32'hFFFF_FFFF, 32'h0000_1000, 0);
        issue(0, WR, 12'h3B1, 32'h0000_1234, 32'h0,         0);
        issue(0, RD, 12'h3B0, 32'h0,         32'h0000_1000, 0);
        issue(0, RD, 12'h3B1, 32'h0,         32'h0,         0);
        n_chk++; if (pa0[0] !== 34'h0_0000_4000 || pa0[1] !== 34'h0)
            $display("FAIL locked_addr_out: got %h %h want %h 0", pa0[0], pa0[1], 34'h0_0000_4000); else n_pass++;
        issue(0, ST, 12'h3A0, 32'h0000_0001, 32'h0000_8900, 0);
        issue(0, RD, 12'h3A0, 32'h0,         32'h0000_8901, 0);
        issue(0, CL, 12'h3A0, 32'h0000_8000, 32'h0000_8901, 0);
        issue(0, WR, 12'h3A0, 32'h0000_0003, 32'h0000_8901, 0);
        issue(0, RD, 12'h3A0, 32'h0,         32'h0000_8903, 0);
        n_chk++; if (cfg0[1].lock !== 1'b1 || cfg0[0].write !== 1'b1)
            $display("FAIL lock_bytes: got L1=%b W0=%b want 1 1", cfg0[1].lock, cfg0[0].write); else n_pass++;
        idle();
    endtask

    task automatic test_err();
        issue(0, RD, 12'h3C5, 32'h0,         32'h0,         1);
        issue(0, WR, 12'h3AF, 32'hFFFF_FFFF, 32'h0,         1);
        issue(0, ST, 12'h3A4, 32'hFFFF_FFFF, 32'h0,         1);
        issue(0, RD, 12'h3B0, 32'h0,         32'h0000_1000, 0);
        issue(0, RD, 12'h3A0, 32'h0,         32'h0000_8903, 0);
        idle();
    endtask

    task automatic test_granularity();
        issue(1, WR, 12'h3A0, 32'h0018_0000, 32'h0,         0);
        issue(1, WR, 12'h3B2, 32'h0,         32'h0000_0001, 0);
        issue(1, RD, 12'h3B2, 32'h0,         32'h0000_0001, 0);
        n_chk++; if (pa1[2] !== 34'h4) $display("FAIL napot_addr_out: got %h want %h", pa1[2], 34'h4); else n_pass++;
        issue(1, WR, 12'h3A0, 32'h0008_0000, 32'h0018_0000, 0);
        issue(1, RD, 12'h3B2, 32'h0,         32'h0,         0);
        n_chk++; if (pa1[2] !== 34'h0) $display("FAIL tor_addr_out: got %h want 0", pa1[2]); else n_pass++;
        issue(1, WR, 12'h3B2, 32'h0000_00FF, 32'h0,         0);
        issue(1, RD, 12'h3B2, 32'h0,         32'h0000_00FC, 0);
        issue(1, WR, 12'h3A0, 32'h0010_0000, 32'h0008_0000, 0);
        issue(1, RD, 12'h3A0, 32'h0,         32'h0008_0000, 0);
        idle();
    endtask

`ifdef IBEX_PMP_CSR_SHADOW_EN
    task automatic test_shadow();
        n_chk++; if (alarm0 !== 1'b0) $display("FAIL alarm_idle: got %b want 0", alarm0); else n_pass++;
        force dut0.g_ent[0].g_impl.u_ent.addr_q = 32'h0000_1001;
        @(posedge clk); #1;
        n_chk++; if (alarm0 !== 1'b1) $display("FAIL alarm_set: got %b want 1", alarm0); else n_pass++;
        release dut0.g_ent[0].g_impl.u_ent.addr_q;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (alarm0 !== 1'b1) $display("FAIL alarm_sticky: got %b want 1", alarm0); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        issue(0, WR, 12'h3B3, 32'h0000_0001, 32'h0000_BEEF, 0);
        req0 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (rv0 !== 1'b0) $display("FAIL rst_drop_rvalid: got %b want 0", rv0); else n_pass++;
        n_chk++; if (pa0[0] !== '0 || pa0[3] !== '0 || cfg0[1] !== '0 || cfg0[0] !== '0)
            $display("FAIL rst_clear: got addr0=%h addr3=%h cfg1=%h want 0", pa0[0], pa0[3], cfg0[1]); else n_pass++;
        n_chk++; if (alarm0 !== 1'b0) $display("FAIL rst_alarm: got %b want 0", alarm0); else n_pass++;
        req0 = 1'b1; op = RD; addr = 12'h3B0;
        #1;
        n_chk++; if (gnt0 !== 1'b0) $display("FAIL gnt_during_rst: got %b want 1'b0", gnt0); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (rv0 !== 1'b0) $display("FAIL req_in_rst: got rvalid %b want 0", rv0); else n_pass++;
        req0 = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        issue(0, RD, 12'h3A0, 32'h0, 32'h0, 0);
        issue(0, WR, 12'h3B0, 32'h0000_0055, 32'h0, 0);
        issue(0, RD, 12'h3B0, 32'h0, 32'h0000_0055, 0);
        idle();
    endtask

    initial begin
        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: got timeout want completion");
                $fatal(1, "timeout");
            end
        join_none
        #1;
        test_reset();
        test_addr();
        test_warl();
        test_lock();
        test_err();
        test_granularity();
`ifdef IBEX_PMP_CSR_SHADOW_EN
        test_shadow();
`endif
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (sbq.size() != 0) $display("FAIL drain: got %0d pending want 0", sbq.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ibex_pmp_csr.md
Name: ibex_pmp_csr

Overview:
- Machine-mode CSR storage for the PMP entries: pmpcfg0-3 and pmpaddr0-15.
- Sits between the CSR access port and the PMP access checker.
- Accepts CSR read/write/set/clear requests and applies the WARL and lock rules.
- Drives the per-region cfg and 34-bit address vectors the checker consumes.

Parameters:
- PMPGranularity, 0: NAPOT/TOR granule; 0 = 4 byte, G = 2^(G+2) byte.
- PMPNumRegions, 4: implemented entries, 1..16; unimplemented entries read 0, writes ignored.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- csr_req_i  in  1  access request, single-cycle pulse.
- csr_gnt_o  out  1  request accepted.
- csr_addr_i  in  12  CSR number.
- csr_op_i  in  2  0 read, 1 write, 2 set, 3 clear.
- csr_wdata_i  in  32  write/set/clear operand.
- csr_rvalid_o  out  1  response valid.
- csr_rdata_o  out  32  read data (old value).
- csr_err_o  out  1  illegal CSR number.
- csr_pmp_cfg_o  out  ibex_pkg::pmp_cfg_t [PMPNumRegions]  per-region cfg (lock, mode, exec, write, read).
- csr_pmp_addr_o  out  34 [PMPNumRegions]  {pmpaddr[31:0], 2'b00}.
- alarm_o  out  1  sticky shadow-mismatch alarm.

Behaviour:
Reset:
- All cfg fields 0 (mode OFF, unlocked); all pmpaddr 0.
- csr_rvalid_o 0, csr_rdata_o 0, csr_err_o 0, alarm_o 0.

Handshake:
- csr_gnt_o = ~rst_i; no backpressure otherwise.
- Accepted request at cycle N gives csr_rvalid_o=1 at N+1 for exactly one cycle, with csr_rdata_o/csr_err_o valid in that cycle.
- Back-to-back requests allowed every cycle.
- A write is visible on the cfg/addr outputs at N+1.
- A read at N+1 of the same register returns the updated value.

Addresses:
- 0x3A0-0x3A3 pmpcfgK; byte j maps to entry 4K+j.
- 0x3B0-0x3BF pmpaddrK.
- Any other address: csr_err_o=1, rdata=0, no state change.
- Reset asserted mid-operation drops the pending response: rvalid=0 in the next cycle.

Read-modify-write:
- new = wdata (write), old|wdata (set), old&~wdata (clear).
- Read op never modifies state.
- Set/clear with wdata=0 modifies nothing.

Cfg byte layout and WARL rules:
- Byte layout: [7] L, [6:5] reserved (read 0), [4:3] A, [2] X, [1] W, [0] R.
- R=0,W=1 is reserved: stored W forced to 0.
- A=NA4 when PMPGranularity>=1: mode keeps its previous value.

Locking:
- Entry i locked (L=1): its cfg byte and pmpaddr i ignore all writes.
- pmpaddr i also locked when entry i+1 has L=1 and mode TOR.
- Lock is cleared only by reset.
- Bytes of one pmpcfg register are updated independently; locked bytes are held while unlocked bytes in the same write update.

Address readback (storage keeps all 32 bits):
- G>=1, mode OFF/TOR: bits [G-1:0] read 0.
- G>=2, mode NAPOT: bits [G-2:0] read 1.
- The same masking applies to csr_pmp_addr_o.

Optional Feature:
IBEX_PMP_CSR_SHADOW_EN:
- Defined: every cfg/addr register has a bit-inverted shadow copy, written in the same cycle.
- A continuous comparator sets alarm_o when any register != ~shadow; alarm_o stays set until reset.
- Reset initialises each shadow to the inverse of the reset value.
- Not defined: no shadow storage; alarm_o tied 0.

Test Plan:
- Write 0x3B0=0x0000_1000, then read 0x3B0: rvalid one cycle later, rdata=0x0000_1000; csr_pmp_addr_o[0]=0x0_0000_4000.
- Write 0x3A0=0x0000_0802 (entry0 R=0,W=1; entry1 TOR): readback 0x0000_0800; cfg[0].write=0.
- Write 0x3A0=0x0000_8900 (entry1 L=1, TOR), then write 0x3B0=0xFFFF_FFFF and 0x3B1=0x1234: both addrs unchanged; set 0x3A0 with 0x0000_0001 sets entry0 R=1 only.
- G=2: write pmpaddr2=0x0000_0000 with mode NAPOT -> reads 0x0000_0001; switch mode to TOR -> reads 0x0000_0000.
- Read 0x3C5 -> err=1, rdata=0; reset high in the cycle after a request -> rvalid=0 and all cfg/addr back to 0.
- With IBEX_PMP_CSR_SHADOW_EN: force-flip one stored addr bit -> alarm_o=1 next cycle and held until reset.
